// File: rtl/opl_timer_probe_accel.sv
// OPL timer-probe accelerator: tracks bank-0 timer preload/control writes and forces a
// timer overflow once enough host reads have been seen while that timer is running.
module opl_timer_probe_accel #(
    parameter int unsigned NUM_TIMERS        = 2,
    parameter int unsigned RD_THRESHOLD      = 50,
    parameter int unsigned MATCH_ANY_PRELOAD = 0,
    parameter int unsigned STAT_WIDTH        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic [1:0]            address,
    input  logic [7:0]            din,
    input  logic                  enable,
    output logic [NUM_TIMERS-1:0] force_timer_overflow,
    output logic [NUM_TIMERS-1:0] armed,
    output logic [STAT_WIDTH-1:0] fire_count
);

    localparam int unsigned CntWidth = $clog2(4 * RD_THRESHOLD + 1);
    localparam int unsigned SumWidth = STAT_WIDTH + 1;
    localparam logic [CntWidth-1:0] Thr1 = CntWidth'(RD_THRESHOLD);
    localparam logic [CntWidth-1:0] Thr2 = CntWidth'(4 * RD_THRESHOLD);

    typedef enum logic [1:0] {StIdle, StArmed, StFired} state_e;

    logic                  cs_n_q, rd_n_q, wr_n_q;
    logic [1:0]            addr_q;
    logic [7:0]            din_q;
    logic                  rd_act, wr_act, wr_edge;
    logic                  rd_act_prev_q, wr_act_prev_q;
    logic                  rd_edge_q, reg_wr_q;
    logic [7:0]            reg_data_q;
    logic                  bank_q;
    logic [7:0]            reg_addr_q, pre1_q, pre2_q;
    logic                  ctl_wr, other_wr;
    state_e                state_q [NUM_TIMERS];
    state_e                state_d [NUM_TIMERS];
    logic [CntWidth-1:0]   cnt_q [NUM_TIMERS];
    logic [CntWidth-1:0]   cnt_d [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] force_q, force_d;
    logic [STAT_WIDTH-1:0] fire_count_q;
    logic [SumWidth-1:0]   fire_sum;

    assign rd_act   = ~cs_n_q & ~rd_n_q;
    assign wr_act   = ~cs_n_q & ~wr_n_q;
    assign wr_edge  = wr_act & ~wr_act_prev_q;
    assign ctl_wr   = reg_wr_q & ~bank_q & (reg_addr_q == 8'h04);
    assign other_wr = reg_wr_q & ~ctl_wr;

    // p1 input stage, then edge detect and write decode
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            addr_q        <= 2'b00;
            din_q         <= 8'h00;
            rd_act_prev_q <= 1'b0;
            wr_act_prev_q <= 1'b0;
            rd_edge_q     <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_data_q    <= 8'h00;
            bank_q        <= 1'b0;
            reg_addr_q    <= 8'h00;
            pre1_q        <= 8'h00;
            pre2_q        <= 8'h00;
        end else begin
            cs_n_q        <= cs_n;
            rd_n_q        <= rd_n;
            wr_n_q        <= wr_n;
            addr_q        <= address;
            din_q         <= din;
            rd_act_prev_q <= rd_act;
            wr_act_prev_q <= wr_act;
            rd_edge_q     <= rd_act & ~rd_act_prev_q;
            reg_wr_q      <= wr_edge & addr_q[0];
            if (wr_edge && addr_q[0]) begin
                reg_data_q <= din_q;
            end
            if (wr_edge && !addr_q[0]) begin
                bank_q     <= addr_q[1];
                reg_addr_q <= din_q;
            end
            if (reg_wr_q && !bank_q && reg_addr_q == 8'h02) begin
                pre1_q <= reg_data_q;
            end
            if (reg_wr_q && !bank_q && reg_addr_q == 8'h03) begin
                pre2_q <= reg_data_q;
            end
        end
    end

    // Priority: enable low, then any write (beats a same-cycle read), then fire/count.
    always_comb begin
        for (int n = 0; n < NUM_TIMERS; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            force_d[n] = 1'b0;
            if (!enable) begin
                state_d[n] = StIdle;
            end else if (ctl_wr) begin
                if (!reg_data_q[7]) begin
                    if (reg_data_q[n] && !reg_data_q[6-n] &&
                        ((MATCH_ANY_PRELOAD != 0) ||
                         (((n == 0) ? pre1_q : pre2_q) == 8'hFF))) begin
                        state_d[n] = StArmed;
                        cnt_d[n]   = '0;
                    end else begin
                        state_d[n] = StIdle;
                    end
                end
            end else if (other_wr) begin
                state_d[n] = StIdle;
            end else if (state_q[n] == StArmed) begin
                if (cnt_q[n] == ((n == 0) ? Thr1 : Thr2)) begin
                    force_d[n] = 1'b1;
                    state_d[n] = StFired;
                end else if (rd_edge_q) begin
                    cnt_d[n] = cnt_q[n] + CntWidth'(1);
                end
            end
        end
    end

    always_comb begin
        fire_sum = SumWidth'(fire_count_q);
        for (int n = 0; n < NUM_TIMERS; n++) begin
            fire_sum = fire_sum + SumWidth'(force_q[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_TIMERS; n++) begin
                state_q[n] <= StIdle;
                cnt_q[n]   <= '0;
            end
            force_q      <= '0;
            fire_count_q <= '0;
        end else begin
            for (int n = 0; n < NUM_TIMERS; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
            force_q      <= force_d;
            fire_count_q <= fire_sum[STAT_WIDTH] ? '1 : fire_sum[STAT_WIDTH-1:0];
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_TIMERS; n++) begin
            armed[n] = (state_q[n] == StArmed);
        end
    end

    assign force_timer_overflow = force_q;
    assign fire_count           = fire_count_q;

endmodule

// File: tb/tb_opl_timer_probe_accel.sv
// Bench for opl_timer_probe_accel: four configurations share one host bus; pulses are
// checked against a scoreboard of expected (instance, bit, cycle) events.
module tb_opl_timer_probe_accel;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [1:0] address = 2'b00;
    logic [7:0] din = 8'h00;
    logic       enable = 1'b1;

    logic [1:0] fto_a, fto_b, fto_c, arm_a, arm_b, arm_c, fc_c;
    logic [0:0] fto_d, arm_d;
    logic [7:0] fc_a, fc_b, fc_d;

    logic [1:0] fto [4];
    logic [1:0] arm [4];
    logic [7:0] fc [4];

    always #5 clk = ~clk;

    opl_timer_probe_accel u_a (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .address(address),
        .din(din), .enable(enable), .force_timer_overflow(fto_a), .armed(arm_a),
        .fire_count(fc_a)
    );
    opl_timer_probe_accel #(.MATCH_ANY_PRELOAD(1)) u_b (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .address(address),
        .din(din), .enable(enable), .force_timer_overflow(fto_b), .armed(arm_b),
        .fire_count(fc_b)
    );
    opl_timer_probe_accel #(.STAT_WIDTH(2)) u_c (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .address(address),
        .din(din), .enable(enable), .force_timer_overflow(fto_c), .armed(arm_c),
        .fire_count(fc_c)
    );
    opl_timer_probe_accel #(.NUM_TIMERS(1)) u_d (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .address(address),
        .din(din), .enable(enable), .force_timer_overflow(fto_d), .armed(arm_d),
        .fire_count(fc_d)
    );

    always_comb begin
        fto[0] = fto_a;  fto[1] = fto_b;  fto[2] = fto_c;  fto[3] = {1'b0, fto_d};
        arm[0] = arm_a;  arm[1] = arm_b;  arm[2] = arm_c;  arm[3] = {1'b0, arm_d};
        fc[0]  = fc_a;   fc[1]  = fc_b;   fc[2]  = {6'b0, fc_c};  fc[3] = fc_d;
    end

    typedef struct {
        logic [7:0] pre1;
        logic [7:0] pre2;
        logic [7:0] ctl;
        int         nreads;
        int         a0, a1, b0, b1;  // read index of each pulse, 0 = never
        logic [1:0] arm_a, arm_b;
    } vec_t;

    typedef struct {
        int dut;
        int bit_i;
        int cyc;
    } ev_t;

    ev_t sb_q[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  rd_idx;
    int  exp_at [4][2];
    int  exp_fc [4];
    int  fc_max [4] = '{255, 255, 3, 255};
    vec_t vecs [5];

    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse must consume exactly one scoreboard entry
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            for (int b = 0; b < 2; b++) begin
                if (fto[d][b]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb_q.size(); k++) begin
                        if (sb_q[k].dut == d && sb_q[k].bit_i == b && sb_q[k].cyc == cyc)
                            idx = k;
                    end
                    n_tests++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL pulse dut%0d bit%0d: unexpected pulse at cycle %0d",
                                 d, b, cyc);
                    end else begin
                        sb_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; address = a; din = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] r, input logic [7:0] d);
        bus_write(2'b00, r);
        bus_write(2'b01, d);
    endtask

    task automatic set_expect(input int a0, input int a1, input int b0, input int b1);
        rd_idx = 0;
        exp_at[0][0] = a0; exp_at[0][1] = a1;
        exp_at[1][0] = b0; exp_at[1][1] = b1;
        exp_at[2][0] = a0; exp_at[2][1] = a1;
        exp_at[3][0] = a0; exp_at[3][1] = 0;
    endtask

    task automatic do_reads(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cs_n = 1'b0; rd_n = 1'b0; address = 2'($urandom_range(0, 3));
            rd_idx++;
            for (int d = 0; d < 4; d++) begin
                for (int b = 0; b < 2; b++) begin
                    if (exp_at[d][b] == rd_idx) begin
                        sb_q.push_back('{d, b, cyc + 4});
                        if (exp_fc[d] < fc_max[d]) exp_fc[d]++;
                    end
                end
            end
            @(negedge clk);
            cs_n = 1'b1; rd_n = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        idle(10);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missed pulses: got %0d outstanding, expected 0", name,
                     sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] ea, input logic [1:0] eb);
        check({name, " armed a"}, 8'(arm[0]), 8'(ea));
        check({name, " armed b"}, 8'(arm[1]), 8'(eb));
        check({name, " armed c"}, 8'(arm[2]), 8'(ea));
        check({name, " armed d"}, 8'(arm[3]), 8'(ea[0]));
    endtask

    task automatic check_fc(input string name);
        for (int d = 0; d < 4; d++) check($sformatf("%s fire_count dut%0d", name, d), fc[d],
                                          8'(exp_fc[d]));
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h00, 8'h21, 50,  50, 0,   50, 0,   2'b01, 2'b01};
        vecs[1] = '{8'hFF, 8'hFF, 8'h42, 200, 0,  200, 0,  200, 2'b10, 2'b10};
        vecs[2] = '{8'h80, 8'h00, 8'h21, 100, 0,  0,   50, 0,   2'b00, 2'b01};
        vecs[3] = '{8'hFF, 8'hFF, 8'h03, 200, 50, 200, 50, 200, 2'b11, 2'b11};
        vecs[4] = '{8'hFF, 8'hFF, 8'h03, 200, 50, 200, 50, 200, 2'b11, 2'b11};
        for (int d = 0; d < 4; d++) exp_fc[d] = 0;
        set_expect(0, 0, 0, 0);

        idle(3);
        reset = 1'b0;
        idle(1);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset force dut%0d", d), 8'(fto[d]), 8'h00);
        end
        check_all("reset", 2'b00, 2'b00);
        check_fc("reset");

        for (int v = 0; v < 5; v++) begin
            write_reg(8'h02, vecs[v].pre1);
            write_reg(8'h03, vecs[v].pre2);
            set_expect(vecs[v].a0, vecs[v].a1, vecs[v].b0, vecs[v].b1);
            write_reg(8'h04, vecs[v].ctl);
            idle(4);
            check_all($sformatf("vec%0d arm", v), vecs[v].arm_a, vecs[v].arm_b);
            do_reads(vecs[v].nreads);
            drain($sformatf("vec%0d", v));
            check_all($sformatf("vec%0d end", v), 2'b00, 2'b00);
            check_fc($sformatf("vec%0d", v));
        end

        // IRQ-reset control write leaves the running count alone
        write_reg(8'h02, 8'hFF);
        set_expect(50, 0, 50, 0);
        write_reg(8'h04, 8'h21);
        do_reads(20);
        write_reg(8'h04, 8'h80);
        idle(4);
        check_all("irq", 2'b01, 2'b01);
        do_reads(30);
        drain("irq");
        check_fc("irq");

        // Write to an unrelated register disarms
        set_expect(0, 0, 0, 0);
        write_reg(8'h04, 8'h21);
        do_reads(20);
        write_reg(8'hB0, 8'h00);
        idle(4);
        check_all("other wr", 2'b00, 2'b00);
        do_reads(40);
        drain("other wr");

        // Reset mid-count
        write_reg(8'h04, 8'h21);
        idle(4);
        check_all("pre reset", 2'b01, 2'b01);
        do_reads(25);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) exp_fc[d] = 0;
        idle(1);
        check_all("mid reset", 2'b00, 2'b00);
        check_fc("mid reset");
        do_reads(40);
        drain("mid reset");
        check_fc("post reset");

        // Enable drop mid-count
        write_reg(8'h02, 8'hFF);
        write_reg(8'h04, 8'h21);
        idle(4);
        check_all("pre enable", 2'b01, 2'b01);
        do_reads(25);
        @(negedge clk);
        enable = 1'b0;
        idle(2);
        check_all("enable low", 2'b00, 2'b00);
        do_reads(40);
        enable = 1'b1;
        drain("enable low");
        check_all("enable back", 2'b00, 2'b00);
        check_fc("enable");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
